// File: rtl/detect_pkg.sv
// detect_pkg: shared FSM state encoding and hit-count width for the frame scheduler.
package detect_pkg;
  localparam int CW = 12;
  typedef enum logic [1:0] {IDLE = 2'd0, STORE = 2'd1, COMPARE = 2'd2, FLUSH = 2'd3} state_t;
endpackage

// File: rtl/frame_edge_detect.sv
// frame_edge_detect: registers frame parity and flags any change of it.
module frame_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic par,
  output logic toggle
);
  logic par_q;
  assign toggle = par != par_q;
  always_ff @(posedge clk)
    par_q <= par;
endmodule

// File: rtl/detect_frame_scheduler.sv
// detect_frame_scheduler: alternates store/compare frames through a FIFO and publishes per-frame hit verdicts.
module detect_frame_scheduler
  import detect_pkg::*;
#(
  parameter int SUBSAMPLE  = 4,
  parameter int X_OFFSET   = 1,
  parameter int ROW_PARITY = 0
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iDVAL,
  input  logic [31:0]   iFrame_Cont,
  input  logic [9:0]    iX_Cont,
  input  logic [8:0]    iY_Cont,
  input  logic          iFifoEmpty,
  input  logic          iFifoFull,
  input  logic          iHit,
  input  logic [CW-1:0] iHitMin,
  output logic          oWrReq,
  output logic          oRdReq,
  output logic          oCmpValid,
  output logic [CW-1:0] oHitCount,
  output logic          oFrameDetect,
  output logic          oResultValid,
  output logic          oObjectActive,
  output logic          oOverflow,
  output logic          oUnderflow,
  output logic [1:0]    oState
);
  state_t state;
  logic toggle, sample, inc;
  logic [9:0] x_off;
  logic [CW-1:0] count, nxt;

  frame_edge_detect u_edge (.clk(iCLK), .rst_n(iRST), .par(iFrame_Cont[0]), .toggle(toggle));

  // x offset wraps modulo 2^10 before the decimation test
  assign x_off  = iX_Cont - 10'(X_OFFSET);
  assign sample = iDVAL & ((x_off & 10'(SUBSAMPLE - 1)) == '0) & (iY_Cont[0] == 1'(ROW_PARITY));
  assign oWrReq = (state == STORE) & sample & ~iFifoFull;
  assign oRdReq = (((state == COMPARE) & sample) | (state == FLUSH)) & ~iFifoEmpty;
  assign inc    = oCmpValid & iHit & ~&count;
  assign nxt    = count + CW'(inc);
  assign oObjectActive = (state == COMPARE) & (count >= iHitMin);
  assign oState = state;

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state        <= IDLE;
      count        <= '0;
      oHitCount    <= '0;
      oFrameDetect <= 1'b0;
      oResultValid <= 1'b0;
      oCmpValid    <= 1'b0;
      oOverflow    <= 1'b0;
      oUnderflow   <= 1'b0;
    end else begin
      oCmpValid    <= (state == COMPARE) & oRdReq;
      oResultValid <= 1'b0;
      count        <= nxt;
      oOverflow    <= toggle ? 1'b0 : oOverflow | ((state == STORE) & sample & iFifoFull);
      oUnderflow   <= toggle ? 1'b0 : oUnderflow | ((state == COMPARE) & sample & iFifoEmpty);
      case (state)
        IDLE:    if (toggle & iFrame_Cont[0]) state <= iFifoEmpty ? STORE : FLUSH;
        STORE:   if (toggle) begin
          state <= COMPARE;
          count <= '0;
        end
        COMPARE: if (toggle) begin
          state        <= iFifoEmpty ? STORE : FLUSH;
          oHitCount    <= nxt;
          oFrameDetect <= (nxt >= iHitMin) & ~oUnderflow;
          oResultValid <= 1'b1;
        end
        FLUSH:   if (iFifoEmpty) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_detect_frame_scheduler.sv
// tb_detect_frame_scheduler: directed checks of store/compare/flush scheduling and verdicts.
module tb_detect_frame_scheduler;
  logic iCLK = 1'b0, iRST, iDVAL, iFifoEmpty, iFifoFull, iHit;
  logic [31:0] iFrame_Cont;
  logic [9:0] iX_Cont;
  logic [8:0] iY_Cont;
  logic [11:0] iHitMin, oHitCount;
  logic oWrReq, oRdReq, oCmpValid, oFrameDetect, oResultValid, oObjectActive, oOverflow, oUnderflow;
  logic [1:0] oState;
  int errors = 0, checks = 0;

  detect_frame_scheduler dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iFrame_Cont(iFrame_Cont), .iX_Cont(iX_Cont),
    .iY_Cont(iY_Cont), .iFifoEmpty(iFifoEmpty), .iFifoFull(iFifoFull), .iHit(iHit),
    .iHitMin(iHitMin), .oWrReq(oWrReq), .oRdReq(oRdReq), .oCmpValid(oCmpValid),
    .oHitCount(oHitCount), .oFrameDetect(oFrameDetect), .oResultValid(oResultValid),
    .oObjectActive(oObjectActive), .oOverflow(oOverflow), .oUnderflow(oUnderflow), .oState(oState)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  task automatic px(input logic d, input int x, input int y);
    iDVAL = d;
    iX_Cont = 10'(x);
    iY_Cont = 9'(y);
    #1;
  endtask

  task automatic frame_edge(input int f, input logic empty);
    iFrame_Cont = f;
    iFifoEmpty = empty;
    tick;
  endtask

  // n hits land on the first n of n+1 qualified compare reads
  task automatic compare_hits(input int n);
    iFifoEmpty = 1'b0;
    for (int i = 0; i <= n; i++) begin
      px(1'b1, 1, 0);
      iHit = (i >= 1);
      tick;
    end
    px(1'b0, 0, 0);
    iHit = 1'b0;
    tick;
  endtask

  initial begin
    int n, nrd, ncv;
    iRST = 1'b0; iFrame_Cont = 0; iDVAL = 1'b0; iX_Cont = '0; iY_Cont = '0;
    iFifoEmpty = 1'b1; iFifoFull = 1'b0; iHit = 1'b0; iHitMin = 12'd30;
    tick; tick;
    check("rst_state", oState, 0);
    check("rst_wr", oWrReq, 0);
    check("rst_rd", oRdReq, 0);
    check("rst_cmpv", oCmpValid, 0);
    check("rst_resv", oResultValid, 0);
    check("rst_hitcnt", oHitCount, 0);
    check("rst_detect", oFrameDetect, 0);
    check("rst_ovf", oOverflow, 0);
    iRST = 1'b1;
    tick;
    check("idle_hold", oState, 0);
    frame_edge(1, 1'b1);
    check("idle_to_store", oState, 1);
    n = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 64; x++) begin
        px(1'b1, x, y);
        if (oWrReq) n++;
        tick;
      end
    check("store_writes_64x8", n, 64);
    px(1'b1, 0, 0);    check("x0_wraps_unsampled", oWrReq, 0);
    px(1'b1, 1021, 0); check("x1021_sampled", oWrReq, 1);
    px(1'b1, 1, 1);    check("odd_row_unsampled", oWrReq, 0);
    px(1'b0, 1, 0);    check("no_dval", oWrReq, 0);
    iFifoFull = 1'b1;
    px(1'b1, 1, 0);    check("full_blocks_wr", oWrReq, 0);
    tick;
    check("overflow_set", oOverflow, 1);
    iFifoFull = 1'b0;
    px(1'b0, 0, 0);
    frame_edge(2, 1'b0);
    check("store_to_compare", oState, 2);
    check("overflow_cleared", oOverflow, 0);
    check("active_low", oObjectActive, 0);
    compare_hits(30);
    check("active_high", oObjectActive, 1);
    frame_edge(3, 1'b1);
    check("compare_to_store", oState, 1);
    check("resv_pulse", oResultValid, 1);
    check("hitcnt_30", oHitCount, 30);
    check("detect_30", oFrameDetect, 1);
    tick;
    check("resv_one_cycle", oResultValid, 0);
    check("hitcnt_held", oHitCount, 30);
    frame_edge(4, 1'b0);
    compare_hits(29);
    frame_edge(5, 1'b1);
    check("hitcnt_29", oHitCount, 29);
    check("detect_29", oFrameDetect, 0);
    frame_edge(6, 1'b0);
    compare_hits(5000);
    frame_edge(7, 1'b1);
    check("hitcnt_sat", oHitCount, 4095);
    check("detect_sat", oFrameDetect, 1);
    frame_edge(8, 1'b0);
    check("compare_again", oState, 2);
    compare_hits(30);
    iFifoEmpty = 1'b1;
    px(1'b1, 1, 0);
    check("rd_blocked_empty", oRdReq, 0);
    tick;
    check("underflow_set", oUnderflow, 1);
    px(1'b0, 0, 0);
    frame_edge(9, 1'b1);
    check("underflow_hitcnt", oHitCount, 30);
    check("underflow_detect", oFrameDetect, 0);
    check("underflow_cleared", oUnderflow, 0);
    frame_edge(10, 1'b0);
    compare_hits(2);
    frame_edge(11, 1'b0);
    check("compare_to_flush", oState, 3);
    nrd = 0; ncv = 0;
    for (int i = 0; i < 6; i++) begin
      iFifoEmpty = (i >= 3);
      if (i == 0) iFrame_Cont = 12;
      if (i == 1) iFrame_Cont = 13;
      #1;
      if (oRdReq) nrd++;
      if (oCmpValid) ncv++;
      tick;
    end
    check("flush_reads", nrd, 3);
    check("flush_no_cmpv", ncv, 0);
    check("flush_to_idle", oState, 0);
    frame_edge(14, 1'b1);
    frame_edge(15, 1'b1);
    check("idle_to_store_2", oState, 1);
    px(1'b1, 1, 0);
    check("store_wr_before_rst", oWrReq, 1);
    iRST = 1'b0;
    tick;
    check("midrst_idle", oState, 0);
    check("midrst_wr", oWrReq, 0);
    check("midrst_resv", oResultValid, 0);
    iRST = 1'b1;
    px(1'b0, 0, 0);
    tick;
    check("post_rst_idle", oState, 0);
    check("post_rst_resv", oResultValid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
